vm2002_gen: RTL and testbench

Parametrised next-generation vending controller core for the vm2002 family. Supports NUM_ITEMS products with programmable count and cost (supplier mode) and a coin-collection purchase flow (user mode) with an inactivity timeout. New relative to the previous generation: coin-by-coin change dispensing, coin rejection on overflow, and an invalid-selection status. Sits between the front-panel/coin-acceptor interface and the dispenser/coin-return mechanics.

---
 rtl/vm2002_gen.sv | 240 ++++++++++++++++++++++++
 tb/tb_vm2002_gen.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/vm2002_gen.sv
// vm2002 vending controller core: supplier stock/cost table, coin collection with timeout,
// greedy coin-by-coin change. Define VM2002_AUTO_VEND_EN to vend as soon as credit covers cost.
module vm2002_gen #(
    parameter int NUM_ITEMS   = 7,
    parameter int ITEM_W      = 3,
    parameter int COUNT_W     = 4,
    parameter int AMT_W       = 8,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic               clk,
    input  logic               hrst_n,
    input  logic               srst,
    input  logic               valid,
    input  logic [ITEM_W-1:0]  item,
    input  logic [COUNT_W-1:0] count,
    input  logic [AMT_W-1:0]   cost,
    input  logic [ITEM_W-1:0]  buttons,
    input  logic [1:0]         coins,
    input  logic               select,
    output logic [1:0]         status,
    output logic               insert_coins,
    output logic               start_timer,
    output logic               timeout,
    output logic               insufficient_amount,
    output logic               coin_reject,
    output logic [AMT_W-1:0]   amount,
    output logic [ITEM_W-1:0]  product,
    output logic               product_vld,
    output logic [AMT_W-1:0]   balance,
    output logic [1:0]         change_coin,
    output logic               change_done
);
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYC);

    localparam logic [1:0] ST_NONE    = 2'd0;
    localparam logic [1:0] ST_AVAIL   = 2'd1;
    localparam logic [1:0] ST_OOS     = 2'd2;
    localparam logic [1:0] ST_INVALID = 2'd3;

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_COLLECT, S_VEND, S_CHANGE} state_t;

    state_t             state_q, state_d;
    logic [ITEM_W-1:0]  sel_q, sel_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [AMT_W-1:0]   amount_q, amount_d;
    logic [AMT_W-1:0]   balance_q, balance_d;
    logic [1:0]         status_q, status_d;
    logic               timeout_q, timeout_d;
    logic               insuf_q, insuf_d;
    logic               reject_q, reject_d;

    logic [COUNT_W-1:0] count_arr [NUM_ITEMS];
    logic [AMT_W-1:0]   cost_arr  [NUM_ITEMS];
    logic [COUNT_W-1:0] sel_count;
    logic [AMT_W-1:0]   sel_cost;
    logic               wr_en;
    logic               coin_in;
    logic [AMT_W:0]     coin_sum;
    logic               coin_fits;
    logic [AMT_W-1:0]   amt_now;
    logic [1:0]         chg_coin;

    function automatic logic [AMT_W-1:0] coin_value(input logic [1:0] c);
        case (c)
            2'd1:    return AMT_W'(5);
            2'd2:    return AMT_W'(10);
            2'd3:    return AMT_W'(25);
            default: return '0;
        endcase
    endfunction

    assign wr_en = (state_q == S_IDLE) && valid && (item != '0) &&
                   (item <= ITEM_W'(NUM_ITEMS)) && ((cost % AMT_W'(5)) == '0);

    // One stock/cost register pair per product; written by the supplier, decremented on vend
    for (genvar gi = 0; gi < NUM_ITEMS; gi++) begin : g_item
        localparam logic [ITEM_W-1:0] IDX = ITEM_W'(gi + 1);
        logic [COUNT_W-1:0] cnt_q;
        logic [AMT_W-1:0]   cst_q;

        always_ff @(posedge clk or negedge hrst_n) begin
            if (!hrst_n) begin
                cnt_q <= '0;
                cst_q <= '0;
            end else if (wr_en && item == IDX) begin
                cnt_q <= count;
                cst_q <= cost;
            end else if (state_q == S_VEND && sel_q == IDX) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end

        assign count_arr[gi] = cnt_q;
        assign cost_arr[gi]  = cst_q;
    end

    always_comb begin
        sel_count = '0;
        sel_cost  = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (sel_q == ITEM_W'(i + 1)) begin
                sel_count = count_arr[i];
                sel_cost  = cost_arr[i];
            end
        end
    end

    assign coin_in   = (coins != 2'd0);
    assign coin_sum  = {1'b0, amount_q} + {1'b0, coin_value(coins)};
    assign coin_fits = !coin_sum[AMT_W];
    assign amt_now   = (coin_in && coin_fits) ? coin_sum[AMT_W-1:0] : amount_q;

    always_comb begin
        chg_coin = 2'd0;
        if (state_q == S_CHANGE) begin
            if (balance_q >= AMT_W'(25))      chg_coin = 2'd3;
            else if (balance_q >= AMT_W'(10)) chg_coin = 2'd2;
            else if (balance_q >= AMT_W'(5))  chg_coin = 2'd1;
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        timer_d   = timer_q;
        amount_d  = amount_q;
        balance_d = balance_q;
        status_d  = status_q;
        timeout_d = 1'b0;
        insuf_d   = 1'b0;
        reject_d  = coin_in;
        case (state_q)
            S_IDLE: begin
                status_d = ST_NONE;
                if (!srst && !valid && buttons != '0) begin
                    sel_d   = buttons;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                state_d = S_IDLE;
                if (srst) begin
                    status_d = ST_NONE;
                end else if (sel_q > ITEM_W'(NUM_ITEMS)) begin
                    status_d = ST_INVALID;
                end else if (sel_count == '0) begin
                    status_d = ST_OOS;
                end else begin
                    status_d = ST_AVAIL;
                    timer_d  = TMR_LOAD;
                    state_d  = S_COLLECT;
                end
            end
            S_COLLECT: begin
                // A same-cycle coin is always banked; decisions use the registered amount
                reject_d = coin_in && !coin_fits;
                amount_d = amt_now;
                if (srst) begin
                    balance_d = amt_now;
                    amount_d  = '0;
                    timer_d   = '0;
                    state_d   = S_CHANGE;
                end else if (select && amount_q >= sel_cost) begin
                    timer_d = '0;
                    state_d = S_VEND;
                end else if (select) begin
                    insuf_d = 1'b1;
                    timer_d = TMR_LOAD;
`ifdef VM2002_AUTO_VEND_EN
                end else if (amount_q >= sel_cost) begin
                    timer_d = '0;
                    state_d = S_VEND;
`endif
                end else if (coin_in && coin_fits) begin
                    timer_d = TMR_LOAD;
                end else if (timer_q <= TMR_W'(1)) begin
                    timeout_d = 1'b1;
                    balance_d = amount_q;
                    amount_d  = '0;
                    timer_d   = '0;
                    state_d   = S_CHANGE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_VEND: begin
                balance_d = amount_q - sel_cost;
                amount_d  = '0;
                state_d   = S_CHANGE;
            end
            S_CHANGE: begin
                if (balance_q == '0) begin
                    status_d = ST_NONE;
                    state_d  = S_IDLE;
                end else begin
                    balance_d = balance_q - coin_value(chg_coin);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge hrst_n) begin
        if (!hrst_n) begin
            state_q   <= S_IDLE;
            sel_q     <= '0;
            timer_q   <= '0;
            amount_q  <= '0;
            balance_q <= '0;
            status_q  <= ST_NONE;
            timeout_q <= 1'b0;
            insuf_q   <= 1'b0;
            reject_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            timer_q   <= timer_d;
            amount_q  <= amount_d;
            balance_q <= balance_d;
            status_q  <= status_d;
            timeout_q <= timeout_d;
            insuf_q   <= insuf_d;
            reject_q  <= reject_d;
        end
    end

    assign status              = status_q;
    assign insert_coins        = (state_q == S_COLLECT);
    assign start_timer         = (state_q == S_COLLECT);
    assign timeout             = timeout_q;
    assign insufficient_amount = insuf_q;
    assign coin_reject         = reject_q;
    assign amount              = amount_q;
    assign product             = (state_q == S_VEND) ? sel_q : '0;
    assign product_vld         = (state_q == S_VEND);
    assign balance             = balance_q;
    assign change_coin         = chg_coin;
    assign change_done         = (state_q == S_CHANGE) && (balance_q == '0);
endmodule

// File: tb/tb_vm2002_gen.sv
// Bench for vm2002_gen: directed purchase scenarios plus randomized supplier writes and purchases
// checked transaction-by-transaction against a stock/credit model of the vending rules.
module tb_vm2002_gen;
    localparam int NI = 6;
    localparam int IW = 3;
    localparam int CW = 4;
    localparam int AW = 8;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          hrst_n, srst, valid, select;
    logic [IW-1:0] item, buttons;
    logic [CW-1:0] count;
    logic [AW-1:0] cost;
    logic [1:0]    coins;
    logic [1:0]    status, change_coin;
    logic          insert_coins, start_timer, timeout, insufficient_amount, coin_reject;
    logic [AW-1:0] amount, balance;
    logic [IW-1:0] product;
    logic          product_vld, change_done;

    always #5 clk = ~clk;

    vm2002_gen #(.NUM_ITEMS(NI), .ITEM_W(IW), .COUNT_W(CW), .AMT_W(AW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .hrst_n(hrst_n), .srst(srst), .valid(valid), .item(item), .count(count),
        .cost(cost), .buttons(buttons), .coins(coins), .select(select), .status(status),
        .insert_coins(insert_coins), .start_timer(start_timer), .timeout(timeout),
        .insufficient_amount(insufficient_amount), .coin_reject(coin_reject), .amount(amount),
        .product(product), .product_vld(product_vld), .balance(balance),
        .change_coin(change_coin), .change_done(change_done)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Event monitor: cumulative counters, sampled on the falling edge
    int m_vld = 0, m_prod = 0, m_chg_sum = 0, m_chg_n = 0, m_done = 0;
    int m_to = 0, m_insuf = 0, m_rej = 0;
    always @(negedge clk) begin
        if (product_vld) begin m_vld++; m_prod = int'(product); end
        if (change_coin == 2'd1) begin m_chg_sum += 5;  m_chg_n++; end
        if (change_coin == 2'd2) begin m_chg_sum += 10; m_chg_n++; end
        if (change_coin == 2'd3) begin m_chg_sum += 25; m_chg_n++; end
        if (change_done) m_done++;
        if (timeout) m_to++;
        if (insufficient_amount) m_insuf++;
        if (coin_reject) m_rej++;
    end

    int mcnt  [0:7];
    int mcost [0:7];
    int coin_q[$];

    function automatic int cval(input int c);
        return (c == 1) ? 5 : (c == 2) ? 10 : (c == 3) ? 25 : 0;
    endfunction

    function automatic int ncoins(input int r);
        return r / 25 + (r % 25) / 10 + ((r % 25) % 10) / 5;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin mcnt[i] = 0; mcost[i] = 0; end
    endtask

    task automatic supply(input int it, input int cn, input int co);
        valid = 1'b1; item = IW'(it); count = CW'(cn); cost = AW'(co);
        step();
        valid = 1'b0;
        if (it >= 1 && it <= NI && co % 5 == 0) begin mcnt[it] = cn; mcost[it] = co; end
        $display("supply item=%0d count=%0d cost=%0d", it, cn, co);
    endtask

    // mode 0: select (sc = coin dropped in the select cycle), 1: wait for timeout, 2: srst
    task automatic buy(input int it, input int mode, input int sc);
        int s_vld, s_sum, s_n, s_done, s_to, s_insuf, s_rej;
        int exp_st, amt, rej, refund;
        bit vend, tmo;
        s_vld = m_vld; s_sum = m_chg_sum; s_n = m_chg_n; s_done = m_done;
        s_to = m_to; s_insuf = m_insuf; s_rej = m_rej;
        exp_st = (it > NI) ? 3 : (mcnt[it] == 0) ? 2 : 1;
        buttons = IW'(it);
        step();
        buttons = '0;
        step();
        check_eq("status", int'(status), exp_st);
        if (exp_st != 1) begin
            step();
            check_eq("status_clear", int'(status), 0);
            $display("buy item=%0d status=%0d", it, exp_st);
            return;
        end
        check_eq("insert_coins", int'(insert_coins), 1);
        amt = 0; rej = 0; vend = 1'b0; tmo = 1'b0;
        foreach (coin_q[k]) begin
            coins = 2'(coin_q[k]);
            step();
            if (amt + cval(coin_q[k]) <= 255) amt += cval(coin_q[k]); else rej++;
        end
        coins = 2'd0;
        check_eq("amount", int'(amount), amt);
        if (mode == 0) begin
            select = 1'b1; coins = 2'(sc);
            step();
            select = 1'b0; coins = 2'd0;
            vend = (amt >= mcost[it]);
            if (amt + cval(sc) <= 255) amt += cval(sc); else rej++;
            tmo = !vend;
        end else if (mode == 1) begin
            tmo = 1'b1;
        end else begin
            srst = 1'b1;
            step();
            srst = 1'b0;
        end
        refund = vend ? amt - mcost[it] : amt;
        for (int k = 0; k < 400 && m_done == s_done; k++) step();
        step();
        check_eq("change_done", m_done - s_done, 1);
        check_eq("vend_pulses", m_vld - s_vld, vend ? 1 : 0);
        if (vend) begin
            check_eq("product", m_prod, it);
            mcnt[it]--;
        end
        check_eq("change_sum", m_chg_sum - s_sum, refund);
        check_eq("change_coins", m_chg_n - s_n, ncoins(refund));
        check_eq("timeouts", m_to - s_to, tmo ? 1 : 0);
        check_eq("insufficient", m_insuf - s_insuf, (mode == 0 && !vend) ? 1 : 0);
        check_eq("coin_rejects", m_rej - s_rej, rej);
        check_eq("status_end", int'(status), 0);
        check_eq("amount_end", int'(amount), 0);
        $display("buy item=%0d mode=%0d vend=%0d refund=%0d rejects=%0d", it, mode, vend, refund, rej);
    endtask

    initial begin
        int s;
        hrst_n = 1'b0; srst = 1'b0; valid = 1'b0; select = 1'b0;
        item = '0; count = '0; cost = '0; buttons = '0; coins = 2'd0;
        model_reset();
        step(); step();
        hrst_n = 1'b1;
        step();
        check_eq("rst_status", int'(status), 0);
        check_eq("rst_amount", int'(amount), 0);
        check_eq("rst_insert", int'(insert_coins), 0);
        check_eq("rst_vld", int'(product_vld), 0);
        check_eq("rst_balance", int'(balance), 0);
        check_eq("rst_chg", int'(change_coin), 0);

        supply(1, 3, 50);  coin_q = '{3, 3};          buy(1, 0, 0);
        supply(5, 4, 100); coin_q = '{3, 3, 3, 3, 3}; buy(5, 0, 0);
        supply(2, 2, 150); coin_q = '{3};             buy(2, 0, 0);
        supply(4, 0, 20);  coin_q = '{};              buy(4, 0, 0);
        buy(7, 0, 0);
        supply(3, 2, 255);
        coin_q = '{3, 3, 3, 3, 3, 3, 3, 3, 3, 3, 2};  buy(3, 2, 0);
        supply(2, 5, 52);
        coin_q = '{3, 3, 3, 3, 3, 3};                 buy(2, 0, 0);
        supply(6, 3, 30);  coin_q = '{2, 2};          buy(6, 0, 3);
        coin_q = '{3, 1};                             buy(6, 0, 2);
        coin_q = '{};                                 buy(1, 1, 0);

        s = m_rej;
        coins = 2'd2; step(); coins = 2'd0; step();
        check_eq("idle_coin_reject", m_rej - s, 1);
        $display("idle coin rejects=%0d", m_rej - s);

        for (int t = 0; t < 40; t++) begin
            int it, md, nc;
            if ($urandom_range(0, 2) == 0) begin
                supply($urandom_range(0, 7), $urandom_range(0, 15),
                       ($urandom_range(0, 1) == 1) ? $urandom_range(0, 51) * 5 : $urandom_range(0, 255));
            end
            it = $urandom_range(1, 7);
            md = $urandom_range(0, 9);
            md = (md < 7) ? 0 : (md < 9) ? 2 : 1;
            nc = $urandom_range(0, 13);
            coin_q.delete();
            for (int k = 0; k < nc; k++) coin_q.push_back($urandom_range(1, 3));
            buy(it, md, (md == 0) ? $urandom_range(0, 3) : 0);
        end

        supply(1, 5, 20);
        buttons = 3'd1; step(); buttons = '0; step();
        coins = 2'd2; step(); coins = 2'd0;
        #2 hrst_n = 1'b0;
        #1;
        check_eq("hrst_insert", int'(insert_coins), 0);
        check_eq("hrst_timer", int'(start_timer), 0);
        check_eq("hrst_amount", int'(amount), 0);
        check_eq("hrst_status", int'(status), 0);
        step();
        hrst_n = 1'b1;
        model_reset();
        $display("hard reset asserted mid-collect");
        step();
        coin_q = '{}; buy(1, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
